// File: rtl/clock_enables.sv
// Clock-enable generator for the 56.7504 MHz system clock.
// Waits for the synthesiser to report a stable lock for LOCK_CYCLES
// consecutive cycles, then releases the system (ready) and produces
// 7.0938 MHz pixel enables and 3.5469 MHz CPU enables from a 4-bit divider.
module clock_enables #(
  parameter int unsigned LOCK_CYCLES = 1024
) (
  input  logic clock56,
  input  logic reset,
  input  logic locked,
  input  logic stall,
  output logic ready,
  output logic ce7n,
  output logic ce7p,
  output logic ce3n,
  output logic ce3p
);

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(LOCK_CYCLES - 32'd1);

  state_t      state;
  state_t      state_nx;
  logic [15:0] hold_cnt;
  logic [15:0] hold_nx;
  logic [3:0]  div;
  logic [3:0]  div_nx;
  logic        locked_m;
  logic        locked_s;
  logic        run;

  // Two-flop synchroniser for the asynchronous lock indication.
  always_ff @(posedge clock56) begin
    if (!reset) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= locked;
      locked_s <= locked_m;
    end
  end

  // Controller state, hold counter and divider registers.
  always_ff @(posedge clock56) begin
    if (!reset) begin
      state    <= WAIT;
      hold_cnt <= '0;
      div      <= '0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
      div      <= div_nx;
    end
  end

  // Next-state logic: divider only advances while staying in RUN, so it
  // is zero on RUN entry and zero everywhere else.
  always_comb begin
    state_nx = state;
    hold_nx  = '0;
    div_nx   = '0;
    case (state)
      WAIT: begin
        if (locked_s) begin
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_nx = WAIT;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nx = RUN;
        end else begin
          hold_nx = hold_cnt + 16'd1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nx = WAIT;
        end else begin
          div_nx = div + 4'd1;
        end
      end
      default: begin
        state_nx = WAIT;
      end
    endcase
  end

  // Output decode from registered state/divider; stall gates CPU enables only.
  always_comb begin
    run   = (state == RUN);
    ready = run;
    ce7n  = run && (div[2:0] == 3'd3);
    ce7p  = run && (div[2:0] == 3'd7);
    ce3n  = run && (div == 4'd7)  && !stall;
    ce3p  = run && (div == 4'd15) && !stall;
  end

endmodule

// File: tb/tb_clock_enables.sv
// Self-checking bench for clock_enables with LOCK_CYCLES = 16.
// Reference model: the system is ready once the synchronised lock has been
// seen high on LOCK_CYCLES+1 consecutive edges; enable phase is the number
// of edges since that point.
module tb_clock_enables;

  localparam int unsigned L = 16;

  logic clock56 = 1'b0;
  logic reset   = 1'b0;
  logic locked  = 1'b0;
  logic stall   = 1'b0;
  logic ready, ce7n, ce7p, ce3n, ce3p;

  clock_enables #(.LOCK_CYCLES(L)) dut (
    .clock56 (clock56),
    .reset   (reset),
    .locked  (locked),
    .stall   (stall),
    .ready   (ready),
    .ce7n    (ce7n),
    .ce7p    (ce7p),
    .ce3n    (ce3n),
    .ce3p    (ce3p)
  );

  always #5 clock56 = ~clock56;

  int unsigned checks = 0;
  int unsigned passes = 0;

  // Model state: locked samples in flight and consecutive-lock edge count.
  bit          m_s1 = 1'b0;
  bit          m_s2 = 1'b0;
  int unsigned m_cnt = 0;

  logic [4:0] exp_v;
  logic [4:0] act_v;

  function automatic logic [4:0] model_out();
    bit          rdy;
    int unsigned ph;
    rdy = (m_cnt >= L + 1);
    ph  = rdy ? (m_cnt - (L + 1)) : 0;
    return {rdy,
            rdy && (ph % 8 == 3),
            rdy && (ph % 8 == 7),
            rdy && (ph % 16 == 7)  && !stall,
            rdy && (ph % 16 == 15) && !stall};
  endfunction

  function automatic int unsigned model_div();
    return (m_cnt >= L + 1) ? ((m_cnt - (L + 1)) % 16) : 0;
  endfunction

  // Advance one edge, update the model with the inputs seen at that edge,
  // and return at the following falling edge with expected/actual loaded.
  task automatic cycle();
    @(posedge clock56);
    if (!reset) begin
      m_s1  = 1'b0;
      m_s2  = 1'b0;
      m_cnt = 0;
    end else begin
      if (m_s2) m_cnt++;
      else      m_cnt = 0;
      m_s2 = m_s1;
      m_s1 = locked;
    end
    @(negedge clock56);
    exp_v = model_out();
    act_v = {ready, ce7n, ce7p, ce3n, ce3p};
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    locked = 1'b1;
    stall  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (act_v !== 5'b00000) $display("FAIL reset_outputs edge %0d: got %b want 00000", i, act_v);
      else passes++;
    end
  endtask

  task automatic test_lock_timing();
    reset  = 1'b1;
    locked = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      cycle();
      checks++;
      if (act_v !== exp_v) $display("FAIL lock_model edge %0d: got %b want %b", k, act_v, exp_v);
      else passes++;
      if (k == 18) begin
        checks++;
        if (ready !== 1'b0) $display("FAIL lock_ready_early edge 18: got %b want 0", ready);
        else passes++;
      end
      if (k == 19) begin
        checks++;
        if (ready !== 1'b1) $display("FAIL lock_ready_rise edge 19: got %b want 1", ready);
        else passes++;
      end
      if (k == 22) begin
        checks++;
        if (ce7n !== 1'b1) $display("FAIL first_ce7n edge 22: got %b want 1", ce7n);
        else passes++;
      end
    end
  endtask

  task automatic test_run_enables();
    int n7n = 0, n7p = 0, n3n = 0, n3p = 0;
    int last3p = -1;
    stall = 1'b0;
    for (int k = 0; k < 64; k++) begin
      cycle();
      checks++;
      if (act_v !== exp_v) $display("FAIL run_model cycle %0d: got %b want %b", k, act_v, exp_v);
      else passes++;
      checks++;
      if ((ce7n && ce7p) || (ce3n && ce3p)) $display("FAIL enable_overlap cycle %0d: got %b want no overlap", k, act_v);
      else passes++;
      n7n += int'(ce7n);
      n7p += int'(ce7p);
      n3n += int'(ce3n);
      if (ce3p) begin
        n3p++;
        if (last3p >= 0) begin
          checks++;
          if (k - last3p !== 16) $display("FAIL ce3p_period: got %0d want 16", k - last3p);
          else passes++;
        end
        last3p = k;
      end
    end
    checks++;
    if ({n7n, n7p, n3n, n3p} !== {32'd8, 32'd8, 32'd4, 32'd4})
      $display("FAIL enable_counts: got %0d %0d %0d %0d want 8 8 4 4", n7n, n7p, n3n, n3p);
    else passes++;
  endtask

  task automatic test_stall();
    bit found = 1'b0;
    for (int i = 0; i < 32 && !found; i++) begin
      cycle();
      if (model_div() == 5) found = 1'b1;
    end
    checks++;
    if (!found) $display("FAIL stall_sync: got timeout want divider 5");
    else passes++;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (act_v !== exp_v) $display("FAIL stall_model div %0d: got %b want %b", 6 + i, act_v, exp_v);
      else passes++;
      if (i == 1) begin
        checks++;
        if ({ce3n, ce7p, ready} !== 3'b011) $display("FAIL stall_div7: got ce3n/ce7p/ready %b want 011", {ce3n, ce7p, ready});
        else passes++;
      end
    end
    stall = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      cycle();
      checks++;
      if (act_v !== exp_v) $display("FAIL stall_after_model: got %b want %b", act_v, exp_v);
      else passes++;
      if (model_div() == 15) found = 1'b1;
    end
    checks++;
    if (!found || ce3p !== 1'b1) $display("FAIL stall_next_ce3p: got %b want 1", ce3p);
    else passes++;
  endtask

  task automatic test_unlock_run();
    locked = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (act_v !== exp_v) $display("FAIL unlock_model edge %0d: got %b want %b", i, act_v, exp_v);
      else passes++;
    end
    checks++;
    if (act_v !== 5'b00000) $display("FAIL unlock_outputs: got %b want 00000", act_v);
    else passes++;
    locked = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      cycle();
      checks++;
      if (act_v !== exp_v) $display("FAIL relock_model edge %0d: got %b want %b", k, act_v, exp_v);
      else passes++;
      if (k == 18 || k == 19) begin
        checks++;
        if (ready !== (k == 19)) $display("FAIL relock_ready edge %0d: got %b want %b", k, ready, k == 19);
        else passes++;
      end
    end
  endtask

  task automatic test_hold_glitch();
    reset = 1'b0;
    cycle();
    reset  = 1'b1;
    locked = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      locked = (k != 12);
      cycle();
      checks++;
      if (act_v !== exp_v) $display("FAIL glitch_model edge %0d: got %b want %b", k, act_v, exp_v);
      else passes++;
      if (k == 19 || k == 30 || k == 31) begin
        checks++;
        if (ready !== (k == 31)) $display("FAIL glitch_ready edge %0d: got %b want %b", k, ready, k == 31);
        else passes++;
      end
    end
  endtask

  task automatic test_reset_in_run();
    bit found = 1'b0;
    for (int i = 0; i < 32 && !found; i++) begin
      cycle();
      if (model_div() == 5) found = 1'b1;
    end
    checks++;
    if (!found || ready !== 1'b1) $display("FAIL rstrun_sync: got ready %b want 1 at divider 5", ready);
    else passes++;
    reset = 1'b0;
    cycle();
    checks++;
    if (act_v !== 5'b00000) $display("FAIL rstrun_outputs: got %b want 00000", act_v);
    else passes++;
    reset = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      cycle();
      checks++;
      if (act_v !== exp_v) $display("FAIL rstrun_model edge %0d: got %b want %b", k, act_v, exp_v);
      else passes++;
      if (k == 18 || k == 19) begin
        checks++;
        if (ready !== (k == 19)) $display("FAIL rstrun_ready edge %0d: got %b want %b", k, ready, k == 19);
        else passes++;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      locked = ($urandom_range(0, 99) != 0);
      stall  = ($urandom_range(0, 3) == 0);
      reset  = ($urandom_range(0, 499) != 0);
      cycle();
      checks++;
      if (act_v !== exp_v) $display("FAIL random_model cycle %0d: got %b want %b", i, act_v, exp_v);
      else passes++;
    end
    reset = 1'b1;
    stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock_timing();
    test_run_enables();
    test_stall();
    test_unlock_run();
    test_hold_glitch();
    test_reset_in_run();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/clock_enables.md
CLOCK_ENABLES -- requirements
Module: clock_enables

Interface
REQ-001 Parameter LOCK_CYCLES, default 1024, number of consecutive clock56 cycles locked must stay high before the system is released (legal range 2..65535).
REQ-002 clock56  input  1  system clock, 56.7504 MHz, synthesiser CLKFX output; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 locked  input  1  synthesiser lock status, asynchronous to clock56.
REQ-005 stall  input  1  CPU contention request; high suppresses CPU enables.
REQ-006 ready  output  1  high = clocks stable, downstream logic may leave reset.
REQ-007 ce7n  output  1  one-cycle 7.0938 MHz pixel enable, falling phase.
REQ-008 ce7p  output  1  one-cycle 7.0938 MHz pixel enable, rising phase.
REQ-009 ce3n  output  1  one-cycle 3.5469 MHz CPU enable, falling phase.
REQ-010 ce3p  output  1  one-cycle 3.5469 MHz CPU enable, rising phase.

Function
REQ-011 locked SHALL pass through a two-flop synchroniser; only the second flop (locked_s) is used by the logic.
REQ-012 The controller SHALL have exactly three states: WAIT, HOLD, RUN.
REQ-013 WAIT -> HOLD on the edge where locked_s=1; hold counter cleared to 0.
REQ-014 In HOLD the 16-bit hold counter SHALL increment by 1 each cycle while locked_s=1.
REQ-015 HOLD -> WAIT on any edge where locked_s=0; hold counter cleared.
REQ-016 HOLD -> RUN on the edge where hold counter = LOCK_CYCLES-1 and locked_s=1.
REQ-017 RUN -> WAIT on any edge where locked_s=0; divider cleared the same edge.
REQ-018 With locked held high, ready SHALL rise after the (LOCK_CYCLES+3)th rising edge counted from the first edge sampling locked=1.
REQ-019 ready SHALL be high iff state = RUN.
REQ-020 A 4-bit divider SHALL be 0 on RUN entry, increment every cycle in RUN, wrap 15 -> 0, and hold 0 outside RUN.
REQ-021 ce7n SHALL be high iff RUN and divider[2:0]=3; ce7p iff RUN and divider[2:0]=7.
REQ-022 ce3n SHALL be high iff RUN, divider=7 and stall=0.
REQ-023 ce3p SHALL be high iff RUN, divider=15 and stall=0.
REQ-024 stall SHALL gate only ce3n/ce3p, never the divider, ce7n/ce7p or ready; a suppressed CPU enable is dropped, not deferred.
REQ-025 All enables SHALL be single-cycle pulses; ce7n/ce7p never coincide; ce3n/ce3p never coincide.
REQ-026 All outputs SHALL be decoded from registered state, divider and stall only; no combinational path from locked to any output.

Reset
REQ-027 reset=0 at a rising edge SHALL force state WAIT, hold counter 0, divider 0, synchroniser flops 0.
REQ-028 During and after reset, ready, ce7n, ce7p, ce3n, ce3p SHALL all be 0 until the REQ-018 sequence completes again.
REQ-029 reset asserted mid-HOLD or mid-RUN SHALL take effect on that edge with no further enable pulse.

Verification
REQ-030 LOCK_CYCLES=16, reset released, locked=1 from edge 1 -> ready=0 through edge 18, ready=1 after edge 19.
REQ-031 RUN, stall=0, 64 cycles -> 8 ce7n, 8 ce7p, 4 ce3n, 4 ce3p; first ce7n 3 cycles after ready rises; ce3p period exactly 16 cycles.
REQ-032 LOCK_CYCLES=16, locked pulled low for one cycle at HOLD count 10 -> state WAIT, ready stays 0, full 16-cycle hold restarts after relock.
REQ-033 RUN, locked dropped -> ready and all enables 0 within 3 edges; divider = 0; relock repeats REQ-030 timing.
REQ-034 RUN, stall=1 across divider values 6..8 -> ce3n absent that period, ce7n/ce7p unaffected, next ce3p appears at divider 15 when stall=0.
REQ-035 reset=0 for one edge while in RUN at divider 5 -> all outputs 0 next cycle; with locked=1, ready returns after LOCK_CYCLES+3 edges.
